// File: rtl/div_arb_pkg.sv
// div_arb_pkg: shared definitions for the divider arbiter slice.
//   state_t      - 2-bit sequencer state (IDLE, ISSUE, BUSY, RESP)
//   DEF_*        - default NUM_REQ / WIDTH / TIMEOUT values
//   id_width()   - requester index width, never less than 1 bit
package div_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam int unsigned DEF_NUM_REQ = 4;
    localparam int unsigned DEF_WIDTH   = 8;
    localparam int unsigned DEF_TIMEOUT = 64;

    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/div_rr_pick.sv
// div_rr_pick: combinational round-robin picker.
//   req      in  NUM_REQ  request vector
//   ptr      in  IDW      highest-priority index for this decision
//   grant    out NUM_REQ  one-hot winner (zero when nothing requested)
//   grant_id out IDW      index of the winner
//   found    out 1        at least one request present
module div_rr_pick
    import div_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned IDW     = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_id,
    output logic               found
);

    int unsigned idx;

    // Scan from ptr upward with wrap; the first hit wins.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found    = 1'b1;
                grant_id = IDW'(idx);
                grant    = NUM_REQ'(1) << idx;
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin arbiter/sequencer sharing one long divider among
// NUM_REQ requesters.
//   clk, reset_n                 clock, async active-low reset
//   req, req_dividend/divisor    per-requester request level and packed operands
//   gnt                          one-cycle one-hot grant (operands captured)
//   resp_valid/id/quotient/remainder/error/timeout  tagged result strobe
//   busy                         sequencer not idle
//   div_start/dividend/divisor   command to the divider
//   div_abort                    one-cycle abort after a timeout
//   div_done/error/quotient/remainder  divider completion
// Optional: define DIV_ARB_TIMEOUT_EN to abort a divide after TIMEOUT BUSY
// cycles; otherwise resp_timeout and div_abort are tied 0.
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    localparam int unsigned IDW    = id_width(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_dividend,
    input  logic [NUM_REQ*WIDTH-1:0] req_divisor,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     resp_valid,
    output logic [IDW-1:0]           resp_id,
    output logic [WIDTH-1:0]         resp_quotient,
    output logic [WIDTH-1:0]         resp_remainder,
    output logic                     resp_error,
    output logic                     resp_timeout,
    output logic                     busy,
    output logic                     div_start,
    output logic [WIDTH-1:0]         div_dividend,
    output logic [WIDTH-1:0]         div_divisor,
    output logic                     div_abort,
    input  logic                     div_done,
    input  logic                     div_error,
    input  logic [WIDTH-1:0]         div_quotient,
    input  logic [WIDTH-1:0]         div_remainder
);

    state_t               state, state_nxt;
    logic [IDW-1:0]       ptr;
    logic [IDW-1:0]       cur_id;
    logic [NUM_REQ-1:0]   pick_grant;
    logic [IDW-1:0]       pick_id;
    logic                 pick_found;
    logic                 tmo_hit;
    logic                 take;

    div_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .req      (req),
        .ptr      (ptr),
        .grant    (pick_grant),
        .grant_id (pick_id),
        .found    (pick_found)
    );

    assign take = (state == ST_IDLE) && pick_found;
    assign busy = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (pick_found) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_BUSY;
            ST_BUSY:  if (div_done || tmo_hit) state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // gnt/div_start/resp_valid are registered from the next-state decode so
    // they are flops yet line up exactly with ISSUE and RESP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            ptr            <= '0;
            cur_id         <= '0;
            gnt            <= '0;
            div_start      <= 1'b0;
            div_dividend   <= '0;
            div_divisor    <= '0;
            resp_valid     <= 1'b0;
            resp_id        <= '0;
            resp_quotient  <= '0;
            resp_remainder <= '0;
            resp_error     <= 1'b0;
        end else begin
            state      <= state_nxt;
            gnt        <= take ? pick_grant : '0;
            div_start  <= take;
            resp_valid <= (state == ST_BUSY) && (state_nxt == ST_RESP);
            if (take) begin
                cur_id       <= pick_id;
                div_dividend <= req_dividend[32'(pick_id)*WIDTH +: WIDTH];
                div_divisor  <= req_divisor[32'(pick_id)*WIDTH +: WIDTH];
            end
            if (state == ST_BUSY) begin
                if (div_done) begin
                    resp_id        <= cur_id;
                    resp_error     <= div_error;
                    resp_quotient  <= div_error ? '0 : div_quotient;
                    resp_remainder <= div_error ? '0 : div_remainder;
                end else if (tmo_hit) begin
                    resp_id        <= cur_id;
                    resp_error     <= 1'b1;
                    resp_quotient  <= '0;
                    resp_remainder <= '0;
                end
            end
            if (state == ST_RESP)
                ptr <= (32'(cur_id) == NUM_REQ - 1) ? '0 : cur_id + 1'b1;
        end
    end

`ifdef DIV_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;
    logic [CNT_W-1:0] tmo_cnt;

    assign tmo_hit = (state == ST_BUSY) && (32'(tmo_cnt) == TIMEOUT - 1);

    // ISSUE always precedes BUSY, so clearing there is clearing on BUSY entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt      <= '0;
            div_abort    <= 1'b0;
            resp_timeout <= 1'b0;
        end else begin
            if (state == ST_ISSUE)
                tmo_cnt <= '0;
            else if (state == ST_BUSY)
                tmo_cnt <= tmo_cnt + 1'b1;
            div_abort <= tmo_hit && !div_done;
            if ((state == ST_BUSY) && (div_done || tmo_hit))
                resp_timeout <= !div_done;
        end
    end
`else
    assign tmo_hit      = 1'b0;
    assign div_abort    = 1'b0;
    assign resp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_div_arbiter.sv
module tb_div_arbiter;
    localparam int NR = 4;
    localparam int W  = 8;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [NR-1:0]   req = '0;
    logic [NR*W-1:0] req_dividend = '0;
    logic [NR*W-1:0] req_divisor = '0;
    logic [NR-1:0]   gnt;
    logic            resp_valid;
    logic [1:0]      resp_id;
    logic [W-1:0]    resp_quotient, resp_remainder;
    logic            resp_error, resp_timeout, busy, div_start, div_abort;
    logic [W-1:0]    div_dividend, div_divisor;
    logic            div_done, div_error;
    logic [W-1:0]    div_quotient, div_remainder;

    int total = 0;
    int bad = 0;

    typedef struct { logic [NR-1:0] g; logic [W-1:0] a; logic [W-1:0] b; } gexp_t;
    typedef struct { logic [1:0] id; logic [W-1:0] q; logic [W-1:0] r; logic err; logic to; } rexp_t;
    gexp_t gq[$];
    rexp_t rq[$];

    // Behavioural divider stand-in: 3-cycle latency, error on divisor 0.
    logic       hang = 1'b0;
    logic       stray = 1'b0;
    logic       m_busy, m_done, m_err;
    logic [1:0] m_cnt;
    logic [W-1:0] m_a, m_b, m_q, m_r;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy <= 0; m_done <= 0; m_err <= 0; m_cnt <= 0;
            m_a <= 0; m_b <= 0; m_q <= 0; m_r <= 0;
        end else begin
            m_done <= 0;
            if (div_start && !hang) begin
                m_busy <= 1; m_cnt <= 2; m_a <= div_dividend; m_b <= div_divisor;
            end else if (div_abort) begin
                m_busy <= 0;
            end else if (m_busy) begin
                if (m_cnt == 0) begin
                    m_busy <= 0; m_done <= 1;
                    m_err <= (m_b == 0);
                    m_q <= (m_b == 0) ? 8'hFF : m_a / m_b;
                    m_r <= (m_b == 0) ? 8'hFF : m_a % m_b;
                end else m_cnt <= m_cnt - 1;
            end
        end
    end

    assign div_done      = m_done | stray;
    assign div_error     = m_err & m_done;
    assign div_quotient  = stray ? 8'h5A : m_q;
    assign div_remainder = stray ? 8'hA5 : m_r;

    div_arbiter #(.NUM_REQ(NR), .WIDTH(W), .TIMEOUT(8)) dut (
        .clk(clk), .reset_n(reset_n), .req(req),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .gnt(gnt), .resp_valid(resp_valid), .resp_id(resp_id),
        .resp_quotient(resp_quotient), .resp_remainder(resp_remainder),
        .resp_error(resp_error), .resp_timeout(resp_timeout), .busy(busy),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_abort(div_abort), .div_done(div_done), .div_error(div_error),
        .div_quotient(div_quotient), .div_remainder(div_remainder)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares grants and responses against the scoreboard queues.
    always @(negedge clk) begin
        if (reset_n) begin
            if (gnt != '0) begin
                if (gq.size() == 0) check("gnt_unexpected", 32'(gnt), 0);
                else begin
                    gexp_t e;
                    e = gq.pop_front();
                    check("gnt", 32'(gnt), 32'(e.g));
                    check("div_start", 32'(div_start), 1);
                    check("div_dividend", 32'(div_dividend), 32'(e.a));
                    check("div_divisor", 32'(div_divisor), 32'(e.b));
                end
            end else if (div_start) check("div_start_without_gnt", 32'(div_start), 0);
            if (resp_valid) begin
                if (rq.size() == 0) check("resp_unexpected", 32'(resp_valid), 0);
                else begin
                    rexp_t e;
                    e = rq.pop_front();
                    check("resp_id", 32'(resp_id), 32'(e.id));
                    check("resp_quotient", 32'(resp_quotient), 32'(e.q));
                    check("resp_remainder", 32'(resp_remainder), 32'(e.r));
                    check("resp_error", 32'(resp_error), 32'(e.err));
                    check("resp_timeout", 32'(resp_timeout), 32'(e.to));
                end
            end
        end
    end

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_dividend[i*W +: W] = a;
        req_divisor[i*W +: W]  = b;
    endtask

    task automatic expect_txn(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] q, input logic [W-1:0] r, input logic err,
                              input logic to);
        gexp_t g;
        rexp_t e;
        g.g = NR'(1) << i; g.a = a; g.b = b;
        e.id = 2'(i); e.q = q; e.r = r; e.err = err; e.to = to;
        gq.push_back(g);
        rq.push_back(e);
    endtask

    // Raise req bit i, drop it once its own gnt is seen.
    task automatic request(input int i);
        bit seen = 0;
        @(negedge clk);
        req[i] = 1'b1;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (gnt[i]) seen = 1;
        end
        req[i] = 1'b0;
        if (!seen) check("gnt_timeout", 0, 1);
    endtask

    task automatic drain();
        int c = 0;
        while ((gq.size() != 0 || rq.size() != 0) && c < 200) begin
            @(negedge clk);
            c++;
        end
        if (gq.size() != 0 || rq.size() != 0) begin
            check("drain_timeout", 32'(rq.size()), 0);
            gq.delete();
            rq.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_div_start", 32'(div_start), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single request from requester 1.
        set_ops(1, 100, 7);
        expect_txn(1, 100, 7, 14, 2, 0, 0);
        request(1);
        drain();

        // Divide by zero, then a follow-up request is still served.
        set_ops(2, 55, 0);
        expect_txn(2, 55, 0, 0, 0, 1, 0);
        request(2);
        drain();
        set_ops(3, 50, 5);
        expect_txn(3, 50, 5, 10, 0, 0, 0);
        request(3);
        drain();

        // Completion strobe while idle must be ignored.
        @(negedge clk); stray = 1'b1;
        @(negedge clk); stray = 1'b0;
        check("stray_done_busy", 32'(busy), 0);
        check("stray_done_resp", 32'(resp_valid), 0);
        repeat (2) @(negedge clk);

        // All four requesting continuously: order 0,1,2,3,0.
        set_ops(0, 200, 9);
        set_ops(1, 255, 16);
        set_ops(2, 81, 9);
        set_ops(3, 7, 10);
        expect_txn(0, 200, 9, 22, 2, 0, 0);
        expect_txn(1, 255, 16, 15, 15, 0, 0);
        expect_txn(2, 81, 9, 9, 0, 0, 0);
        expect_txn(3, 7, 10, 0, 7, 0, 0);
        expect_txn(0, 200, 9, 22, 2, 0, 0);
        @(negedge clk);
        req = 4'b1111;
        n = 0;
        for (int c = 0; c < 200 && n < 5; c++) begin
            @(negedge clk);
            if (gnt != '0) n++;
        end
        req = '0;
        check("rr_grant_count", 32'(n), 5);
        drain();

        // Requester 3 drops req right after the decision edge.
        set_ops(3, 99, 4);
        expect_txn(3, 99, 4, 24, 3, 0, 0);
        @(negedge clk);
        req = 4'b1000;
        @(negedge clk);
        req = '0;
        drain();

        // Reset mid-BUSY: no response, outputs cleared, pointer back to 0.
        set_ops(1, 10, 3);
        begin
            gexp_t g;
            g.g = 4'b0010; g.a = 10; g.b = 3;
            gq.push_back(g);
        end
        request(1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_gnt", 32'(gnt), 0);
        check("arst_div_dividend", 32'(div_dividend), 0);
        check("arst_resp_quotient", 32'(resp_quotient), 0);
        check("arst_resp_id", 32'(resp_id), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        check("arst_no_pending_gnt", 32'(gq.size()), 0);
        expect_txn(0, 200, 9, 22, 2, 0, 0);
        @(negedge clk);
        req = 4'b1111;
        n = 0;
        for (int c = 0; c < 50 && n == 0; c++) begin
            @(negedge clk);
            if (gnt != '0) n++;
        end
        req = '0;
        drain();

`ifdef DIV_ARB_TIMEOUT_EN
        // Divider never completes: abort 9 cycles after div_start.
        hang = 1'b1;
        expect_txn(0, 200, 9, 0, 0, 1, 1);
        @(negedge clk);
        req = 4'b0001;
        n = -1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (div_start) begin req = '0; n = 0; end
            else if (n >= 0) n++;
            if (div_abort) break;
        end
        check("timeout_abort_delay", 32'(n), 9);
        drain();
        hang = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
